// File: rtl/node_seq_ctrl.sv
// Root/inner-node sequencer: drives N children over the ST/RD level handshake,
// serially or in parallel, with per-stage timeout and a saturating run-cycle counter.
module node_seq_ctrl #(
    parameter int W    = 16,
    parameter int N    = 2,
    parameter int MODE = 0,
    parameter int TMO  = 0,
    parameter int CW   = 16
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           ST,
    output logic           RD,
    output logic           ERR,
    output logic [W-1:0]   RES,
    output logic [CW-1:0]  CYC,
    output logic [N-1:0]   CH_ST,
    input  logic [N-1:0]   CH_RD,
    input  logic [N*W-1:0] CH_RES
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int WW = (TMO > 0) ? $clog2(TMO + 1) : 1;
    localparam logic [WW:0]  TMO_V      = (WW + 1)'(TMO);
    localparam logic [N-1:0] START_MASK = (MODE != 0) ? {N{1'b1}} : N'(1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERR} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic [CW-1:0]   run_q, run_d;
    logic            rd_q, rd_d;
    logic            err_q, err_d;
    logic [W-1:0]    res_q, res_d;
    logic [CW-1:0]   cyc_q, cyc_d;
    logic [N-1:0]    ch_st_q, ch_st_d;

    logic            stage_rd;
    logic            stage_last;
    logic [WW:0]     wait_inc;
    logic            tmo_hit;

    // In parallel mode the whole group is one stage; serial mode walks idx.
    generate
        if (MODE != 0) begin : g_par
            assign stage_rd   = &CH_RD;
            assign stage_last = 1'b1;
        end else begin : g_ser
            assign stage_rd   = CH_RD[idx_q];
            assign stage_last = (idx_q == IW'(N - 1));
        end
    endgenerate

    assign wait_inc = {1'b0, wait_q} + 1'b1;
    assign tmo_hit  = (TMO > 0) && (wait_inc >= TMO_V);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        run_d   = run_q;
        rd_d    = 1'b0;
        err_d   = 1'b0;
        res_d   = res_q;
        cyc_d   = cyc_q;
        ch_st_d = '0;
        case (state_q)
            S_IDLE: begin
                if (ST) begin
                    state_d = S_RUN;
                    idx_d   = '0;
                    wait_d  = '0;
                    run_d   = '0;
                    ch_st_d = START_MASK;
                end
            end
            S_RUN: begin
                if (!ST) begin
                    state_d = S_IDLE;
                end else begin
                    run_d = (run_q == {CW{1'b1}}) ? run_q : run_q + 1'b1;
                    // A ready child takes priority over a timeout in the same cycle.
                    if (stage_rd && stage_last) begin
                        state_d = S_DONE;
                        rd_d    = 1'b1;
                        res_d   = CH_RES[(N-1)*W +: W];
                        cyc_d   = run_q;
                        ch_st_d = ch_st_q;
                    end else if (stage_rd) begin
                        idx_d   = idx_q + 1'b1;
                        wait_d  = '0;
                        ch_st_d = ch_st_q | (START_MASK << (idx_q + 1'b1));
                    end else if (tmo_hit) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        wait_d  = wait_inc[WW] ? wait_q : wait_inc[WW-1:0];
                        ch_st_d = ch_st_q;
                    end
                end
            end
            S_DONE: begin
                if (!ST) begin
                    state_d = S_IDLE;
                end else begin
                    rd_d    = 1'b1;
                    ch_st_d = ch_st_q;
                end
            end
            S_ERR: begin
                if (!ST) begin
                    state_d = S_IDLE;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            wait_q  <= '0;
            run_q   <= '0;
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
            res_q   <= '0;
            cyc_q   <= '0;
            ch_st_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            run_q   <= run_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            res_q   <= res_d;
            cyc_q   <= cyc_d;
            ch_st_q <= ch_st_d;
        end
    end

    assign RD    = rd_q;
    assign ERR   = err_q;
    assign RES   = res_q;
    assign CYC   = cyc_q;
    assign CH_ST = ch_st_q;

endmodule

// File: tb/tb_node_seq_ctrl.sv
// Bench for node_seq_ctrl: three configurations (serial+timeout, parallel+timeout,
// serial no-timeout with narrow counter) checked against an arithmetic timing model.
module tb_node_seq_ctrl;
    localparam int NCH = 3;
    localparam int W   = 16;
    localparam int MODE_A[3] = '{0, 1, 0};
    localparam int TMO_A[3]  = '{6, 7, 0};
    localparam int CW_A[3]   = '{16, 16, 4};

    logic CLK = 1'b0;
    logic rst;
    always #5 CLK = ~CLK;

    logic           st[3];
    logic           rd_o[3];
    logic           err_o[3];
    logic [W-1:0]   res_o[3];
    logic [15:0]    cyc_o[3];
    logic [NCH-1:0] ch_st[3];
    logic [NCH-1:0] ch_rd[3];
    logic [NCH*W-1:0] ch_res[3];

    int lat[3][NCH];
    int cnt[3][NCH];
    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] m_res[3];
    logic [15:0]  m_cyc[3];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            logic [CW_A[gi]-1:0] cyc_w;
            node_seq_ctrl #(
                .W(W), .N(NCH), .MODE(MODE_A[gi]), .TMO(TMO_A[gi]), .CW(CW_A[gi])
            ) u_dut (
                .CLK(CLK), .RST(rst), .ST(st[gi]), .RD(rd_o[gi]), .ERR(err_o[gi]),
                .RES(res_o[gi]), .CYC(cyc_w), .CH_ST(ch_st[gi]), .CH_RD(ch_rd[gi]),
                .CH_RES(ch_res[gi])
            );
            assign cyc_o[gi] = 16'(cyc_w);
        end
    endgenerate

    // Child model: ready (and held) once its start has been high for lat cycles.
    always @(posedge CLK) begin
        for (int m = 0; m < 3; m++)
            for (int k = 0; k < NCH; k++)
                cnt[m][k] <= ch_st[m][k] ? cnt[m][k] + 1 : 0;
    end

    always_comb begin
        for (int m = 0; m < 3; m++)
            for (int k = 0; k < NCH; k++)
                ch_rd[m][k] = ch_st[m][k] && (cnt[m][k] >= lat[m][k]);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_lat(input int m, input int a, input int b, input int c);
        lat[m][0] = a;
        lat[m][1] = b;
        lat[m][2] = c;
        ch_res[m] = {16'($urandom), 32'($urandom)};
    endtask

    // kind: 0 = normal, 1 = abort on the final-ready cycle, 2 = reset pulse in stage 1
    task automatic run_txn(input int m, input int kind_in);
        int evt, c, t, lmax, rst_cyc, cap, kind;
        bit exp_err;
        logic [W-1:0] new_res;
        kind    = kind_in;
        new_res = ch_res[m][(NCH-1)*W +: W];
        exp_err = 1'b0;
        evt     = 0;
        if (MODE_A[m] == 0) begin
            t = 1;
            for (int k = 0; k < NCH; k++) begin
                if (!exp_err) begin
                    if (TMO_A[m] > 0 && lat[m][k] >= TMO_A[m]) begin
                        exp_err = 1'b1;
                        evt     = t + TMO_A[m];
                    end else begin
                        t += lat[m][k] + 1;
                    end
                end
            end
            if (!exp_err) evt = t;
        end else begin
            lmax = 0;
            for (int k = 0; k < NCH; k++) if (lat[m][k] > lmax) lmax = lat[m][k];
            if (TMO_A[m] > 0 && lmax >= TMO_A[m]) begin
                exp_err = 1'b1;
                evt     = 1 + TMO_A[m];
            end else begin
                evt = lmax + 2;
            end
        end
        if (exp_err && kind == 1) kind = 0;
        rst_cyc = lat[m][0] + 2;
        st[m] = 1'b1;
        for (c = 1; c <= 300; c++) begin
            tick();
            if (kind == 2 && c == rst_cyc) begin
                rst   = 1'b1;
                st[m] = 1'b0;
                tick();
                rst = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    check_eq($sformatf("d%0d_rst_rd", j), 64'(rd_o[j]), 64'd0);
                    check_eq($sformatf("d%0d_rst_err", j), 64'(err_o[j]), 64'd0);
                    check_eq($sformatf("d%0d_rst_res", j), 64'(res_o[j]), 64'd0);
                    check_eq($sformatf("d%0d_rst_cyc", j), 64'(cyc_o[j]), 64'd0);
                    check_eq($sformatf("d%0d_rst_chst", j), 64'(ch_st[j]), 64'd0);
                    m_res[j] = '0;
                    m_cyc[j] = '0;
                end
                $display("txn dut%0d reset-in-stage1 lat=%0d/%0d/%0d at cycle %0d",
                         m, lat[m][0], lat[m][1], lat[m][2], c);
                tick();
                return;
            end
            if (kind == 1 && c == evt - 1) st[m] = 1'b0;
            if (rd_o[m] || err_o[m]) break;
            if (kind == 1 && c == evt) break;
        end
        check_eq($sformatf("d%0d_evt_cycle", m), 64'(c), 64'(evt));
        if (kind == 1) begin
            check_eq($sformatf("d%0d_abort_rd", m), 64'(rd_o[m]), 64'd0);
            check_eq($sformatf("d%0d_abort_err", m), 64'(err_o[m]), 64'd0);
            check_eq($sformatf("d%0d_abort_chst", m), 64'(ch_st[m]), 64'd0);
            check_eq($sformatf("d%0d_abort_res", m), 64'(res_o[m]), 64'(m_res[m]));
            $display("txn dut%0d abort lat=%0d/%0d/%0d evt=%0d obs=%0d",
                     m, lat[m][0], lat[m][1], lat[m][2], evt, c);
            tick();
            return;
        end
        if (!exp_err) begin
            cap      = (1 << CW_A[m]) - 1;
            m_res[m] = new_res;
            m_cyc[m] = 16'((evt - 2 > cap) ? cap : evt - 2);
        end
        check_eq($sformatf("d%0d_err", m), 64'(err_o[m]), 64'(exp_err));
        check_eq($sformatf("d%0d_rd", m), 64'(rd_o[m]), 64'(!exp_err));
        check_eq($sformatf("d%0d_res", m), 64'(res_o[m]), 64'(m_res[m]));
        check_eq($sformatf("d%0d_cyc", m), 64'(cyc_o[m]), 64'(m_cyc[m]));
        check_eq($sformatf("d%0d_chst", m), 64'(ch_st[m]), exp_err ? 64'd0 : 64'd7);
        tick();
        check_eq($sformatf("d%0d_hold_rd", m), 64'(rd_o[m]), 64'(!exp_err));
        check_eq($sformatf("d%0d_hold_err", m), 64'(err_o[m]), 64'(exp_err));
        st[m] = 1'b0;
        tick();
        check_eq($sformatf("d%0d_idle_rd", m), 64'(rd_o[m]), 64'd0);
        check_eq($sformatf("d%0d_idle_err", m), 64'(err_o[m]), 64'd0);
        check_eq($sformatf("d%0d_idle_chst", m), 64'(ch_st[m]), 64'd0);
        check_eq($sformatf("d%0d_idle_res", m), 64'(res_o[m]), 64'(m_res[m]));
        $display("txn dut%0d %s lat=%0d/%0d/%0d evt=%0d obs=%0d res=%0h cyc=%0d",
                 m, exp_err ? "timeout" : "done", lat[m][0], lat[m][1], lat[m][2],
                 evt, c, res_o[m], cyc_o[m]);
        tick();
    endtask

    initial begin
        int m, kind;
        rst = 1'b1;
        for (int j = 0; j < 3; j++) begin
            st[j]     = 1'b0;
            ch_res[j] = '0;
            m_res[j]  = '0;
            m_cyc[j]  = '0;
            for (int k = 0; k < NCH; k++) lat[j][k] = 0;
        end
        repeat (3) tick();
        for (int j = 0; j < 3; j++) begin
            check_eq($sformatf("d%0d_por_rd", j), 64'(rd_o[j]), 64'd0);
            check_eq($sformatf("d%0d_por_err", j), 64'(err_o[j]), 64'd0);
            check_eq($sformatf("d%0d_por_res", j), 64'(res_o[j]), 64'd0);
            check_eq($sformatf("d%0d_por_cyc", j), 64'(cyc_o[j]), 64'd0);
            check_eq($sformatf("d%0d_por_chst", j), 64'(ch_st[j]), 64'd0);
        end
        rst = 1'b0;
        tick();

        set_lat(0, 3, 2, 0);
        ch_res[0][(NCH-1)*W +: W] = 16'h1234;
        run_txn(0, 0);
        set_lat(0, 0, 0, 0); run_txn(0, 0);
        set_lat(0, 0, 0, 0); run_txn(0, 0);
        set_lat(0, 255, 0, 0); run_txn(0, 0);
        set_lat(0, 5, 0, 0); run_txn(0, 0);
        set_lat(0, 1, 6, 0); run_txn(0, 0);
        set_lat(1, 2, 5, 4); run_txn(1, 0);
        set_lat(1, 1, 7, 2); run_txn(1, 0);
        set_lat(1, 6, 1, 1); run_txn(1, 0);
        set_lat(0, 2, 3, 1); run_txn(0, 1);
        set_lat(1, 2, 5, 4); run_txn(1, 1);
        set_lat(0, 1, 4, 2); run_txn(0, 2);
        set_lat(0, 0, 1, 0); run_txn(0, 0);
        set_lat(2, 6, 6, 6); run_txn(2, 0);
        set_lat(2, 1, 1, 1); run_txn(2, 0);

        for (int i = 0; i < 40; i++) begin
            m = $urandom_range(0, 2);
            set_lat(m, $urandom_range(0, 8), $urandom_range(0, 8), $urandom_range(0, 8));
            kind = ($urandom_range(0, 5) == 0) ? 1 : 0;
            if (m == 0 && lat[0][0] < TMO_A[0] && $urandom_range(0, 9) == 0) kind = 2;
            run_txn(m, kind);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
